axi_burst_ctrl: RTL and testbench

- Sequences the cache-line shift buffer (512-bit block, 32-bit word port) against an AXI4 master port.
- Performs line refill (AR/R burst, words shifted in) and dirty-line writeback (AW/W/B burst, words shifted out).
- Drives the buffer's write_en / start_read / start_write controls; sits between the cache FSM and the AXI interconnect.

---
 rtl/axi_burst_ctrl_pkg.sv | 27 ++
 rtl/axi_burst_ctrl_if.sv | 60 ++++++
 rtl/axi_beat_counter.sv | 27 ++
 rtl/axi_burst_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_axi_burst_ctrl.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_burst_ctrl_pkg.sv
// Shared types and constants for the cache-line AXI burst controller.
// Widths, beat count, AXI encodings and the controller state enum.
package axi_burst_ctrl_pkg;

    localparam int unsigned AXI_DATA_WIDTH = 32;
    localparam int unsigned AXI_ADDR_WIDTH = 32;
    localparam int unsigned LINE_WIDTH     = 512;
    localparam int unsigned BEATS          = LINE_WIDTH / AXI_DATA_WIDTH;
    localparam int unsigned CNT_WIDTH      = $clog2(BEATS);
    localparam int unsigned STRB_WIDTH     = AXI_DATA_WIDTH / 8;

    localparam logic [7:0] AXI_LEN    = 8'(BEATS - 1);
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_B,
        ST_DONE
    } state_t;

endpackage

// File: rtl/axi_burst_ctrl_if.sv
// AXI4 master-port bundle between the burst controller and the interconnect.
// master: controller side (drives o_* signals); slave: interconnect side.
interface axi_burst_ctrl_if;
    import axi_burst_ctrl_pkg::*;

    logic                      o_arvalid;
    logic                      i_arready;
    logic [AXI_ADDR_WIDTH-1:0] o_araddr;
    logic [7:0]                o_arlen;
    logic [2:0]                o_arsize;
    logic [1:0]                o_arburst;

    logic                      i_rvalid;
    logic                      o_rready;
    logic                      i_rlast;
    logic [1:0]                i_rresp;

    logic                      o_awvalid;
    logic                      i_awready;
    logic [AXI_ADDR_WIDTH-1:0] o_awaddr;
    logic [7:0]                o_awlen;
    logic [2:0]                o_awsize;
    logic [1:0]                o_awburst;

    logic                      o_wvalid;
    logic                      i_wready;
    logic                      o_wlast;
    logic [STRB_WIDTH-1:0]     o_wstrb;

    logic                      i_bvalid;
    logic                      o_bready;
    logic [1:0]                i_bresp;

    modport master (
        output o_arvalid, o_araddr, o_arlen, o_arsize, o_arburst,
        input  i_arready,
        input  i_rvalid, i_rlast, i_rresp,
        output o_rready,
        output o_awvalid, o_awaddr, o_awlen, o_awsize, o_awburst,
        input  i_awready,
        output o_wvalid, o_wlast, o_wstrb,
        input  i_wready,
        input  i_bvalid, i_bresp,
        output o_bready
    );

    modport slave (
        input  o_arvalid, o_araddr, o_arlen, o_arsize, o_arburst,
        output i_arready,
        output i_rvalid, i_rlast, i_rresp,
        input  o_rready,
        input  o_awvalid, o_awaddr, o_awlen, o_awsize, o_awburst,
        output i_awready,
        input  o_wvalid, o_wlast, o_wstrb,
        output i_wready,
        output i_bvalid, i_bresp,
        input  o_bready
    );

endinterface

// File: rtl/axi_beat_counter.sv
// Beat counter shared by the R and W bursts.
// Ports: clk, arst (async, active-low), clr (priority), inc,
//        cnt (current beat index), last_c (cnt is the final beat).
module axi_beat_counter
    import axi_burst_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 clr,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 last_c
);

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

    assign last_c = (cnt == CNT_WIDTH'(BEATS - 1));

endmodule

// File: rtl/axi_burst_ctrl.sv
// Sequences the cache-line shift buffer against an AXI4 master port:
// line refill (AR/R burst) and dirty-line writeback (AW/W/B burst).
// Ports: clk, arst (async, active-low); i_read_req/i_rd_addr and
//        i_write_req/i_wr_addr from the cache FSM; bus = AXI master port;
//        o_buf_write_en/o_buf_start_read/o_buf_start_write drive the buffer;
//        o_busy, o_done (1-cycle pulse), o_err (qualified by o_done).
module axi_burst_ctrl
    import axi_burst_ctrl_pkg::*;
(
    input  logic                      clk,
    input  logic                      arst,
    input  logic                      i_read_req,
    input  logic                      i_write_req,
    input  logic [AXI_ADDR_WIDTH-1:0] i_rd_addr,
    input  logic [AXI_ADDR_WIDTH-1:0] i_wr_addr,
    axi_burst_ctrl_if.master          bus,
    output logic                      o_buf_write_en,
    output logic                      o_buf_start_read,
    output logic                      o_buf_start_write,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_err
);

    state_t                    state_q, state_d;
    logic                      err_q, err_d;
    logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic                      cnt_clr, cnt_inc;
    logic [CNT_WIDTH-1:0]      cnt;
    logic                      cnt_last_c;
    logic                      wlast_d;

    logic arvalid_q, rready_q, awvalid_q, wvalid_q, wlast_q, bready_q;
    logic start_read_q, start_write_q, busy_q, done_q, err_out_q;

    axi_beat_counter u_beat_counter (
        .clk    (clk),
        .arst   (arst),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .cnt    (cnt),
        .last_c (cnt_last_c)
    );

    // Next-state, address latch, error accumulation and counter control.
    // Valids are registered high for the whole state, so ready alone marks a handshake.
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        araddr_d = araddr_q;
        awaddr_d = awaddr_q;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_write_req) begin
                    state_d  = ST_AW;
                    awaddr_d = i_wr_addr;
                    err_d    = 1'b0;
                    cnt_clr  = 1'b1;
                end else if (i_read_req) begin
                    state_d  = ST_AR;
                    araddr_d = i_rd_addr;
                    err_d    = 1'b0;
                    cnt_clr  = 1'b1;
                end
            end
            ST_AR: begin
                if (bus.i_arready) begin
                    state_d = ST_R;
                    cnt_clr = 1'b1;
                end
            end
            ST_R: begin
                if (bus.i_rvalid) begin
                    cnt_inc = 1'b1;
                    // rlast must coincide exactly with the final beat
                    if ((bus.i_rresp != RESP_OKAY) || (bus.i_rlast != cnt_last_c)) begin
                        err_d = 1'b1;
                    end
                    if (cnt_last_c) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_AW: begin
                if (bus.i_awready) begin
                    state_d = ST_W;
                    cnt_clr = 1'b1;
                end
            end
            ST_W: begin
                if (bus.i_wready) begin
                    cnt_inc = 1'b1;
                    if (cnt_last_c) begin
                        state_d = ST_B;
                    end
                end
            end
            ST_B: begin
                if (bus.i_bvalid) begin
                    if (bus.i_bresp != RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // wlast tracks the beat index the counter will hold next cycle.
    always_comb begin
        wlast_d = 1'b0;
        if ((state_d == ST_W) && (state_q == ST_W)) begin
            wlast_d = cnt_inc ? (cnt == CNT_WIDTH'(BEATS - 2)) : cnt_last_c;
        end
    end

    // State, latched addresses and registered outputs.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q       <= ST_IDLE;
            err_q         <= 1'b0;
            araddr_q      <= '0;
            awaddr_q      <= '0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            wlast_q       <= 1'b0;
            bready_q      <= 1'b0;
            start_read_q  <= 1'b0;
            start_write_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_out_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            err_q         <= err_d;
            araddr_q      <= araddr_d;
            awaddr_q      <= awaddr_d;
            arvalid_q     <= (state_d == ST_AR);
            rready_q      <= (state_d == ST_R);
            awvalid_q     <= (state_d == ST_AW);
            wvalid_q      <= (state_d == ST_W);
            wlast_q       <= wlast_d;
            bready_q      <= (state_d == ST_B);
            start_read_q  <= (state_d == ST_AR) || (state_d == ST_R);
            start_write_q <= (state_d == ST_AW) || (state_d == ST_W) || (state_d == ST_B);
            busy_q        <= (state_d != ST_IDLE);
            done_q        <= (state_d == ST_DONE);
            err_out_q     <= (state_d == ST_DONE) && err_d;
        end
    end

    assign bus.o_arvalid = arvalid_q;
    assign bus.o_araddr  = araddr_q;
    assign bus.o_arlen   = AXI_LEN;
    assign bus.o_arsize  = SIZE_4B;
    assign bus.o_arburst = BURST_INCR;
    assign bus.o_rready  = rready_q;
    assign bus.o_awvalid = awvalid_q;
    assign bus.o_awaddr  = awaddr_q;
    assign bus.o_awlen   = AXI_LEN;
    assign bus.o_awsize  = SIZE_4B;
    assign bus.o_awburst = BURST_INCR;
    assign bus.o_wvalid  = wvalid_q;
    assign bus.o_wlast   = wlast_q;
    assign bus.o_wstrb   = {STRB_WIDTH{1'b1}};
    assign bus.o_bready  = bready_q;

    // Buffer shifts in the same cycle as the data handshake.
    assign o_buf_write_en    = (rready_q & bus.i_rvalid) | (wvalid_q & bus.i_wready);
    assign o_buf_start_read  = start_read_q;
    assign o_buf_start_write = start_write_q;
    assign o_busy            = busy_q;
    assign o_done            = done_q;
    assign o_err             = err_out_q;

endmodule

// File: tb/tb_axi_burst_ctrl.sv
// Self-checking bench for axi_burst_ctrl: acts as a randomised AXI slave
// and line buffer, and predicts each transaction's outcome from its own
// choices (beat counts, stall cycles, injected errors).
module tb_axi_burst_ctrl;

    logic        clk = 1'b0;
    logic        arst;
    logic        i_read_req, i_write_req;
    logic [31:0] i_rd_addr, i_wr_addr;
    logic        o_buf_write_en, o_buf_start_read, o_buf_start_write;
    logic        o_busy, o_done, o_err;

    int n_cmp = 0;
    int n_bad = 0;

    axi_burst_ctrl_if bus ();

    axi_burst_ctrl dut (
        .clk               (clk),
        .arst              (arst),
        .i_read_req        (i_read_req),
        .i_write_req       (i_write_req),
        .i_rd_addr         (i_rd_addr),
        .i_wr_addr         (i_wr_addr),
        .bus               (bus.master),
        .o_buf_write_en    (o_buf_write_en),
        .o_buf_start_read  (o_buf_start_read),
        .o_buf_start_write (o_buf_start_write),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_err             (o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_slave();
        bus.i_arready = 1'b0;
        bus.i_rvalid  = 1'b0;
        bus.i_rlast   = 1'b0;
        bus.i_rresp   = 2'b00;
        bus.i_awready = 1'b0;
        bus.i_wready  = 1'b0;
        bus.i_bvalid  = 1'b0;
        bus.i_bresp   = 2'b00;
    endtask

    function automatic logic [11:0] ctl_vec();
        return {bus.o_arvalid, bus.o_rready, bus.o_awvalid, bus.o_wvalid, bus.o_wlast,
                bus.o_bready, o_buf_write_en, o_buf_start_read, o_buf_start_write,
                o_busy, o_done, o_err};
    endfunction

    // Refill: err_beat injects a non-OKAY rresp (-1 none); rlast_beat is the beat
    // carrying rlast (-1 none); abort_beat pulls arst during that beat (-1 none).
    task automatic do_refill(input logic [31:0] addr, input int err_beat, input int rlast_beat,
                             input bit stall, input int abort_beat);
        int d, ar_cnt, cyc, beats, gaps, we_cnt, we_bad, ctl_bad, guard, done_cyc;
        bit started, ar_done, got_done, err_seen, exp_err, exp_we;
        logic [31:0]  ar_seen;
        logic [12:0]  ar_attr;
        logic [511:0] bufm, exp_buf;
        d = stall ? int'($urandom_range(0, 3)) : 0;
        ar_cnt = 0; cyc = 0; beats = 0; gaps = 0; we_cnt = 0; we_bad = 0;
        ctl_bad = 0; guard = 0; done_cyc = 0;
        started = 0; ar_done = 0; got_done = 0; err_seen = 0;
        ar_seen = '0; ar_attr = '0; bufm = '0;
        @(negedge clk);
        chk("idle_before_refill", {o_busy, o_done}, 2'b00);
        i_read_req = 1'b1;
        i_rd_addr  = addr;
        while (!got_done && guard < 300) begin
            @(negedge clk);
            guard++;
            if (!started && o_busy) begin
                started    = 1;
                i_read_req = 1'b0;
            end
            if (started) cyc++;
            if (o_done) begin
                got_done = 1;
                err_seen = o_err;
                done_cyc = cyc;
                if (o_buf_start_read || o_buf_start_write) ctl_bad++;
            end else if (started && (!o_buf_start_read || o_buf_start_write || o_err)) begin
                ctl_bad++;
            end
            bus.i_arready = 1'b0;
            if (bus.o_arvalid) begin
                bus.i_arready = (ar_cnt >= d);
                ar_cnt++;
            end
            bus.i_rvalid = 1'b0;
            bus.i_rlast  = 1'b0;
            bus.i_rresp  = 2'b00;
            if (ar_done && beats < 16) begin
                if (!stall || $urandom_range(0, 2) != 0) begin
                    bus.i_rvalid = 1'b1;
                    bus.i_rlast  = (beats == rlast_beat);
                    bus.i_rresp  = (beats == err_beat) ? 2'(2 + $urandom_range(0, 1)) : 2'b00;
                end else begin
                    gaps++;
                end
            end
            if (abort_beat >= 0 && beats == abort_beat) begin
                #2;
                arst = 1'b0;
                #1;
                chk("rst_async_outputs", ctl_vec(), 12'h000);
                chk("rst_async_araddr", bus.o_araddr, 32'h0);
                clear_slave();
                i_read_req = 1'b0;
                repeat (2) @(negedge clk);
                arst = 1'b1;
                @(negedge clk);
                chk("rst_release_idle", ctl_vec(), 12'h000);
                return;
            end
            #1;
            exp_we = bus.i_rvalid && bus.o_rready;
            if (o_buf_write_en !== exp_we) we_bad++;
            if (o_buf_write_en) we_cnt++;
            if (bus.o_arvalid && bus.i_arready) begin
                ar_done = 1;
                ar_seen = bus.o_araddr;
                ar_attr = {bus.o_arlen, bus.o_arsize, bus.o_arburst};
            end
            if (bus.i_rvalid && bus.o_rready) begin
                bufm = {32'(beats), bufm[511:32]};
                beats++;
            end
        end
        exp_err = (err_beat >= 0) || (rlast_beat != 15);
        for (int i = 0; i < 16; i++) exp_buf[i*32 +: 32] = 32'(i);
        chk("refill_done_seen", got_done, 1'b1);
        chk("refill_araddr", ar_seen, addr);
        chk("refill_ar_attr", ar_attr, {8'd15, 3'b010, 2'b01});
        chk("refill_beats", beats, 16);
        chk("refill_write_en_count", we_cnt, 16);
        chk("refill_write_en_timing", we_bad, 0);
        chk("refill_buffer_ctl", ctl_bad, 0);
        chk("refill_latency", done_cyc, (d + 1) + 16 + gaps + 1);
        chk("refill_err", err_seen, exp_err);
        chk("refill_buffer_image", bufm, exp_buf);
        clear_slave();
    endtask

    // Writeback: wpat 0 = wready always high, 1 = low every other cycle, 2 = random.
    task automatic do_writeback(input logic [31:0] addr, input bit berr, input int wpat,
                                input bit stall);
        int d, bd, aw_cnt, b_cnt, cyc, wbeats, wgaps, we_cnt, we_bad, ctl_bad, ar_bad;
        int wlast_cnt, wlast_bad, guard, done_cyc;
        bit started, aw_done, b_done, got_done, err_seen, alt, exp_we;
        logic [31:0] aw_seen;
        logic [12:0] aw_attr;
        logic [3:0]  strb_seen;
        d  = stall ? int'($urandom_range(0, 3)) : 0;
        bd = stall ? int'($urandom_range(0, 3)) : 0;
        aw_cnt = 0; b_cnt = 0; cyc = 0; wbeats = 0; wgaps = 0; we_cnt = 0; we_bad = 0;
        ctl_bad = 0; ar_bad = 0; wlast_cnt = 0; wlast_bad = 0; guard = 0; done_cyc = 0;
        started = 0; aw_done = 0; b_done = 0; got_done = 0; err_seen = 0; alt = 0;
        aw_seen = '0; aw_attr = '0; strb_seen = '0;
        @(negedge clk);
        chk("idle_before_writeback", {o_busy, o_done}, 2'b00);
        i_write_req = 1'b1;
        i_wr_addr   = addr;
        while (!got_done && guard < 300) begin
            @(negedge clk);
            guard++;
            if (!started && o_busy) begin
                started     = 1;
                i_write_req = 1'b0;
            end
            if (started) cyc++;
            if (bus.o_arvalid) ar_bad++;
            if (o_done) begin
                got_done = 1;
                err_seen = o_err;
                done_cyc = cyc;
                if (o_buf_start_read || o_buf_start_write) ctl_bad++;
            end else if (started && (o_buf_start_read || !o_buf_start_write || o_err)) begin
                ctl_bad++;
            end
            if (bus.o_wvalid && (bus.o_wlast != (wbeats == 15))) wlast_bad++;
            bus.i_awready = 1'b0;
            if (bus.o_awvalid) begin
                bus.i_awready = (aw_cnt >= d);
                aw_cnt++;
            end
            bus.i_wready = 1'b0;
            if (aw_done && wbeats < 16) begin
                case (wpat)
                    0: bus.i_wready = 1'b1;
                    1: begin
                        bus.i_wready = alt;
                        alt = !alt;
                    end
                    default: bus.i_wready = 1'($urandom_range(0, 1));
                endcase
                if (!bus.i_wready) wgaps++;
            end
            bus.i_bvalid = 1'b0;
            bus.i_bresp  = 2'b00;
            if (wbeats == 16 && !b_done) begin
                bus.i_bvalid = (b_cnt >= bd);
                b_cnt++;
                if (bus.i_bvalid && berr) bus.i_bresp = 2'(2 + $urandom_range(0, 1));
            end
            #1;
            exp_we = bus.o_wvalid && bus.i_wready;
            if (o_buf_write_en !== exp_we) we_bad++;
            if (o_buf_write_en) we_cnt++;
            if (bus.o_awvalid && bus.i_awready) begin
                aw_done = 1;
                aw_seen = bus.o_awaddr;
                aw_attr = {bus.o_awlen, bus.o_awsize, bus.o_awburst};
            end
            if (bus.o_wvalid && bus.i_wready) begin
                if (bus.o_wlast) wlast_cnt++;
                strb_seen = bus.o_wstrb;
                wbeats++;
            end
            if (bus.i_bvalid && bus.o_bready) b_done = 1;
        end
        chk("wb_done_seen", got_done, 1'b1);
        chk("wb_awaddr", aw_seen, addr);
        chk("wb_aw_attr", aw_attr, {8'd15, 3'b010, 2'b01});
        chk("wb_no_ar_issued", ar_bad, 0);
        chk("wb_beats", wbeats, 16);
        chk("wb_wlast_count", wlast_cnt, 1);
        chk("wb_wlast_position", wlast_bad, 0);
        chk("wb_wstrb", strb_seen, 4'hF);
        chk("wb_write_en_count", we_cnt, 16);
        chk("wb_write_en_timing", we_bad, 0);
        chk("wb_buffer_ctl", ctl_bad, 0);
        chk("wb_latency", done_cyc, (d + 1) + 16 + wgaps + (bd + 1) + 1);
        chk("wb_err", err_seen, berr);
        clear_slave();
    endtask

    initial begin
        arst        = 1'b0;
        i_read_req  = 1'b0;
        i_write_req = 1'b0;
        i_rd_addr   = '0;
        i_wr_addr   = '0;
        clear_slave();
        repeat (3) @(negedge clk);
        chk("reset_outputs", ctl_vec(), 12'h000);
        arst = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", ctl_vec(), 12'h000);

        do_refill(32'h0000_1040, -1, 15, 1'b0, -1);
        do_writeback(32'h0000_2080, 1'b0, 1, 1'b0);

        // Both requests together: writeback first, held read served afterwards.
        i_read_req = 1'b1;
        i_rd_addr  = 32'h3000_00C0;
        do_writeback(32'h4000_0100, 1'b0, 0, 1'b0);
        do_refill(32'h3000_00C0, -1, 15, 1'b0, -1);

        do_refill(32'h0000_5000, 5, 15, 1'b0, -1);
        do_refill(32'h0000_5040, -1, 15, 1'b0, -1);
        do_refill(32'h0000_6000, -1, 10, 1'b0, -1);
        do_refill(32'h0000_6040, -1, -1, 1'b0, -1);
        do_refill(32'h0000_7000, -1, 15, 1'b0, 7);
        do_refill(32'h0000_7040, -1, 15, 1'b0, -1);
        do_writeback(32'h0000_8000, 1'b1, 0, 1'b0);

        for (int t = 0; t < 24; t++) begin
            logic [31:0] a;
            int eb, rl;
            a = $urandom & 32'hFFFF_FFC0;
            if ($urandom_range(0, 1) == 1) begin
                eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
                rl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) - 1 : 15;
                do_refill(a, eb, rl, 1'b1, -1);
            end else begin
                do_writeback(a, $urandom_range(0, 3) == 0, 2, 1'b1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
